// File: rtl/tank_motion.sv
// Per-player tank motion controller: keycode decode, fixed-point position and
// heading, clamp/wrap edge handling and a spawn/respawn sequencer.
module tank_motion #(
  parameter int          FRAC_BITS      = 7,
  parameter int          X_MAX          = 639,
  parameter int          Y_MAX          = 479,
  parameter int          SIZE           = 16,
  parameter int          X_START        = 320,
  parameter int          Y_START        = 240,
  parameter int          ANGLE_START    = 0,
  parameter int          SPEED          = 1,
  parameter int          ROT_DIV        = 4,
  parameter int          EDGE_MODE      = 0,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [7:0]  KEY_FWD        = 8'h1A,
  parameter logic [7:0]  KEY_BACK       = 8'h16,
  parameter logic [7:0]  KEY_LEFT       = 8'h04,
  parameter logic [7:0]  KEY_RIGHT      = 8'h07,
  parameter logic [7:0]  KEY_ROTL       = 8'h50,
  parameter logic [7:0]  KEY_ROTR       = 8'h4F
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [63:0]       keycode,
  input  logic              enable,
  input  logic              respawn,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  output logic [9:0]        S,
  output logic [5:0]        Angle,
  output logic signed [7:0] X_vec,
  output logic signed [7:0] Y_vec,
  output logic              visible,
  output logic              at_edge,
  output logic [1:0]        state_o
);
  localparam int PW = FRAC_BITS + 12;
  localparam int RW = (ROT_DIV < 2) ? 1 : $clog2(ROT_DIV + 1);
  localparam int CW = (RESPAWN_FRAMES > 16) ? $clog2(RESPAWN_FRAMES) : 4;
  localparam logic signed [PW-1:0] X_SPAWN   = PW'(X_START * (1 << FRAC_BITS));
  localparam logic signed [PW-1:0] Y_SPAWN   = PW'(Y_START * (1 << FRAC_BITS));
  localparam logic signed [PW-1:0] SPD       = PW'(SPEED);
  localparam logic [5:0]           ANG_SPAWN = 6'(ANGLE_START);
  localparam logic [RW-1:0]        ROT_TOP   = RW'(ROT_DIV);
  localparam logic [CW-1:0]        RESP_LOAD = CW'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACTIVE = 2'b01, S_RESPAWN = 2'b10} state_t;

  state_t                 state_q;
  logic signed [PW-1:0]   pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic [5:0]             angle_q, angle_d;
  logic [RW-1:0]          rot_cnt_q, rot_cnt_d;
  logic [CW-1:0]          resp_cnt_q;
  logic                   at_edge_q;
  logic                   fwd, back, left, right, rot_l, rot_r, rot_step, edge_x, edge_y;
  logic signed [PW-1:0]   xv, yv, tfx, tfy, tlx, tly, dx, dy;

  function automatic logic key_hit(input logic [63:0] kc, input logic [7:0] code);
    for (int i = 0; i < 8; i++)
      if (kc[8*i +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  // First quadrant of round(127*cos(2*pi*k/64)), k = 0..16.
  function automatic logic signed [7:0] quarter_cos(input logic [4:0] k);
    case (k)
      5'd0:  return 8'sd127;  5'd1:  return 8'sd126;  5'd2:  return 8'sd125;
      5'd3:  return 8'sd122;  5'd4:  return 8'sd117;  5'd5:  return 8'sd112;
      5'd6:  return 8'sd106;  5'd7:  return 8'sd98;   5'd8:  return 8'sd90;
      5'd9:  return 8'sd81;   5'd10: return 8'sd71;   5'd11: return 8'sd60;
      5'd12: return 8'sd49;   5'd13: return 8'sd37;   5'd14: return 8'sd25;
      5'd15: return 8'sd12;   default: return 8'sd0;
    endcase
  endfunction

  function automatic logic signed [7:0] cos_rom(input logic [5:0] a);
    logic [5:0] idx;
    if (a <= 6'd16) return quarter_cos(a[4:0]);
    if (a <= 6'd32) begin idx = 6'd32 - a; return -quarter_cos(idx[4:0]); end
    if (a <= 6'd48) begin idx = a - 6'd32; return -quarter_cos(idx[4:0]); end
    idx = 6'd0 - a;
    return quarter_cos(idx[4:0]);
  endfunction

  function automatic logic signed [7:0] sin_rom(input logic [5:0] a);
    return cos_rom(a - 6'd16);
  endfunction

  // Returns {hit, corrected position} for one axis.
  function automatic logic [PW:0] edge_fix(input logic signed [PW-1:0] nxt, input int max_v);
    logic signed [PW-1:0] ip, lo, hi, top, span;
    ip   = nxt >>> FRAC_BITS;
    lo   = PW'(SIZE);
    hi   = PW'(max_v - SIZE);
    top  = PW'(max_v);
    span = PW'((max_v + 1) * (1 << FRAC_BITS));
    if (EDGE_MODE == 0) begin
      if (ip < lo) return {1'b1, lo <<< FRAC_BITS};
      if (ip > hi) return {1'b1, hi <<< FRAC_BITS};
    end else begin
      if (nxt < 0)   return {1'b1, nxt + span};
      if (ip > top)  return {1'b1, nxt - span};
    end
    return {1'b0, nxt};
  endfunction

  always_comb begin
    fwd   = key_hit(keycode, KEY_FWD)   & ~key_hit(keycode, KEY_BACK);
    back  = key_hit(keycode, KEY_BACK)  & ~key_hit(keycode, KEY_FWD);
    left  = key_hit(keycode, KEY_LEFT)  & ~key_hit(keycode, KEY_RIGHT);
    right = key_hit(keycode, KEY_RIGHT) & ~key_hit(keycode, KEY_LEFT);
    rot_l = key_hit(keycode, KEY_ROTL)  & ~key_hit(keycode, KEY_ROTR);
    rot_r = key_hit(keycode, KEY_ROTR)  & ~key_hit(keycode, KEY_ROTL);
    xv  = {{(PW-8){X_vec[7]}}, X_vec};
    yv  = {{(PW-8){Y_vec[7]}}, Y_vec};
    tfx = fwd  ? xv : (back  ? -xv : '0);
    tfy = fwd  ? yv : (back  ? -yv : '0);
    tlx = left ? xv : (right ? -xv : '0);
    tly = left ? yv : (right ? -yv : '0);
    dx  = (tfx + tly) * SPD;
    dy  = (tfy - tlx) * SPD;
    {edge_x, pos_x_d} = edge_fix(pos_x_q + dx, X_MAX);
    {edge_y, pos_y_d} = edge_fix(pos_y_q + dy, Y_MAX);
    // rot_cnt counts frames since the last step; zero means the key was just pressed.
    rot_step  = (rot_cnt_q == '0) || (rot_cnt_q == ROT_TOP);
    angle_d   = angle_q;
    rot_cnt_d = '0;
    if (rot_l | rot_r) begin
      rot_cnt_d = rot_step ? RW'(1) : rot_cnt_q + RW'(1);
      if (rot_step) angle_d = rot_r ? angle_q + 6'd1 : angle_q - 6'd1;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pos_x_q    <= X_SPAWN;
      pos_y_q    <= Y_SPAWN;
      angle_q    <= ANG_SPAWN;
      rot_cnt_q  <= '0;
      resp_cnt_q <= '0;
      at_edge_q  <= 1'b0;
    end else begin
      at_edge_q <= 1'b0;
      rot_cnt_q <= '0;
      case (state_q)
        S_IDLE: if (enable) state_q <= S_ACTIVE;
        S_ACTIVE: begin
          if (respawn) begin
            state_q    <= S_RESPAWN;
            pos_x_q    <= X_SPAWN;
            pos_y_q    <= Y_SPAWN;
            angle_q    <= ANG_SPAWN;
            resp_cnt_q <= RESP_LOAD;
          end else if (!enable) begin
            state_q <= S_IDLE;
          end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            angle_q   <= angle_d;
            rot_cnt_q <= rot_cnt_d;
            at_edge_q <= edge_x | edge_y;
          end
        end
        S_RESPAWN: begin
          if (respawn)                 resp_cnt_q <= RESP_LOAD;
          else if (resp_cnt_q == '0)   state_q    <= enable ? S_ACTIVE : S_IDLE;
          else                         resp_cnt_q <= resp_cnt_q - CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign X       = pos_x_q[FRAC_BITS +: 10];
  assign Y       = pos_y_q[FRAC_BITS +: 10];
  assign S       = 10'(SIZE);
  assign Angle   = angle_q;
  assign X_vec   = cos_rom(angle_q);
  assign Y_vec   = sin_rom(angle_q);
  assign visible = (state_q == S_RESPAWN) ? resp_cnt_q[3] : 1'b1;
  assign at_edge = at_edge_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_tank_motion.sv
// Randomised bench for tank_motion: a clamp instance and a wrap instance run
// side by side against a plain-arithmetic model of the motion rules.
module tb_tank_motion;
  localparam int ONE = 128;
  localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_A = 8'h04, K_D = 8'h07, K_LA = 8'h50, K_RA = 8'h4F;
  localparam logic [7:0] KEYS [6] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h50, 8'h4F};
  localparam int P_EDGE [2] = '{0, 1};
  localparam int P_ROT  [2] = '{4, 1};
  localparam int P_SPD  [2] = '{1, 2};

  logic        frame_clk = 1'b0;
  logic        Reset, enable, respawn;
  logic [63:0] keycode;
  logic [9:0]        x_o [2], y_o [2], s_o [2];
  logic [5:0]        ang_o [2];
  logic signed [7:0] xv_o [2], yv_o [2];
  logic              vis_o [2], edge_o [2];
  logic [1:0]        st_o [2];

  int n_checks, n_fail;
  int m_st [2], m_px [2], m_py [2], m_ang [2], m_held [2], m_resp [2], m_edge [2];

  tank_motion u_clamp (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .enable(enable), .respawn(respawn),
    .X(x_o[0]), .Y(y_o[0]), .S(s_o[0]), .Angle(ang_o[0]), .X_vec(xv_o[0]), .Y_vec(yv_o[0]),
    .visible(vis_o[0]), .at_edge(edge_o[0]), .state_o(st_o[0]));

  tank_motion #(.EDGE_MODE(1), .ROT_DIV(1), .SPEED(2)) u_wrap (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .enable(enable), .respawn(respawn),
    .X(x_o[1]), .Y(y_o[1]), .S(s_o[1]), .Angle(ang_o[1]), .X_vec(xv_o[1]), .Y_vec(yv_o[1]),
    .visible(vis_o[1]), .at_edge(edge_o[1]), .state_o(st_o[1]));

  always #5 frame_clk = ~frame_clk;

  task automatic check_val(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int trig(input int a, input bit sine);
    real th, v;
    th = 2.0 * 3.14159265358979323846 * a / 64.0;
    v  = 127.0 * (sine ? $sin(th) : $cos(th));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int pressed(input logic [63:0] kc, input logic [7:0] code);
    for (int i = 0; i < 8; i++) if (kc[8*i +: 8] == code) return 1;
    return 0;
  endfunction

  function automatic int floor_px(input int p);
    return (p >= 0) ? p / ONE : -((-p + ONE - 1) / ONE);
  endfunction

  function automatic int fix_axis(input int p, input int maxv, input int mode, output int hit);
    hit = 0;
    if (mode == 0) begin
      if (floor_px(p) < 16)        begin hit = 1; return 16 * ONE; end
      if (floor_px(p) > maxv - 16) begin hit = 1; return (maxv - 16) * ONE; end
      return p;
    end
    if (p < 0)                 begin hit = 1; return p + (maxv + 1) * ONE; end
    if (p >= (maxv + 1) * ONE) begin hit = 1; return p - (maxv + 1) * ONE; end
    return p;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_px[m] = 320 * ONE; m_py[m] = 240 * ONE;
      m_ang[m] = 0; m_held[m] = 0; m_resp[m] = 0; m_edge[m] = 0;
    end
  endtask

  task automatic model_step();
    int fb, lr, rot, cv, sv, ex, ey;
    if (Reset) begin model_reset(); return; end
    for (int m = 0; m < 2; m++) begin
      case (m_st[m])
        0: begin
          m_edge[m] = 0; m_held[m] = 0;
          if (enable) m_st[m] = 1;
        end
        1: begin
          if (respawn) begin
            m_st[m] = 2; m_px[m] = 320 * ONE; m_py[m] = 240 * ONE; m_ang[m] = 0;
            m_resp[m] = 59; m_edge[m] = 0; m_held[m] = 0;
          end else if (!enable) begin
            m_st[m] = 0; m_edge[m] = 0; m_held[m] = 0;
          end else begin
            fb  = pressed(keycode, K_W)  - pressed(keycode, K_S);
            lr  = pressed(keycode, K_A)  - pressed(keycode, K_D);
            rot = pressed(keycode, K_RA) - pressed(keycode, K_LA);
            cv  = trig(m_ang[m], 1'b0);
            sv  = trig(m_ang[m], 1'b1);
            m_px[m] = fix_axis(m_px[m] + P_SPD[m] * (fb * cv + lr * sv), 639, P_EDGE[m], ex);
            m_py[m] = fix_axis(m_py[m] + P_SPD[m] * (fb * sv - lr * cv), 479, P_EDGE[m], ey);
            m_edge[m] = ex | ey;
            if (rot != 0) begin
              m_held[m]++;
              if ((m_held[m] - 1) % P_ROT[m] == 0) m_ang[m] = (m_ang[m] + rot + 64) % 64;
            end else m_held[m] = 0;
          end
        end
        default: begin
          m_edge[m] = 0; m_held[m] = 0;
          if (respawn)             m_resp[m] = 59;
          else if (m_resp[m] == 0) m_st[m] = enable ? 1 : 0;
          else                     m_resp[m]--;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("x%0d", m),     x_o[m],   floor_px(m_px[m]));
      check_val($sformatf("y%0d", m),     y_o[m],   floor_px(m_py[m]));
      check_val($sformatf("s%0d", m),     s_o[m],   16);
      check_val($sformatf("ang%0d", m),   ang_o[m], m_ang[m]);
      check_val($sformatf("xvec%0d", m),  xv_o[m],  trig(m_ang[m], 1'b0));
      check_val($sformatf("yvec%0d", m),  yv_o[m],  trig(m_ang[m], 1'b1));
      check_val($sformatf("state%0d", m), st_o[m],  m_st[m]);
      check_val($sformatf("vis%0d", m),   vis_o[m], (m_st[m] == 2) ? ((m_resp[m] >> 3) & 1) : 1);
      check_val($sformatf("edge%0d", m),  edge_o[m], m_edge[m]);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    @(negedge frame_clk);
    check_outputs();
  endtask

  task automatic random_keys();
    int r;
    keycode = '0;
    for (int s = 0; s < 8; s++) begin
      r = $urandom_range(0, 13);
      if (r < 6)       keycode[8*s +: 8] = KEYS[r];
      else if (r == 6) keycode[8*s +: 8] = 8'($urandom);
    end
  endtask

  initial begin
    int prev_x, hold;
    n_checks = 0; n_fail = 0;
    Reset = 1'b1; enable = 1'b0; respawn = 1'b0; keycode = '0;
    model_reset();
    tick();
    check_val("rst_x", x_o[0], 320);   check_val("rst_y", y_o[0], 240);
    check_val("rst_ang", ang_o[0], 0); check_val("rst_s", s_o[0], 16);
    check_val("rst_state", st_o[0], 0); check_val("rst_vis", vis_o[0], 1);
    check_val("rst_xvec", xv_o[0], 127); check_val("rst_yvec", yv_o[0], 0);

    Reset = 1'b0; enable = 1'b1;
    tick();
    check_val("go_active", st_o[0], 1);
    keycode = {48'h0, K_W, 8'h00};
    tick(); check_val("fwd_f1_x", x_o[0], 320);
    tick(); check_val("fwd_f2_x", x_o[0], 321); check_val("fwd_f2_y", y_o[0], 240);

    keycode = {48'h0, K_S, K_W};
    repeat (3) tick();
    keycode = {48'h0, K_D, K_A};
    repeat (3) tick();
    check_val("cancel_x", x_o[0], 321); check_val("cancel_y", y_o[0], 240);
    check_val("cancel_edge", edge_o[0], 0);

    keycode = {56'h0, K_RA};
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) check_val("rot_f1", ang_o[0], 1);
      if (i == 5) check_val("rot_f5", ang_o[0], 2);
      if (i == 9) check_val("rot_f9", ang_o[0], 3);
    end
    keycode = {48'h0, K_LA, K_RA};
    repeat (4) tick();
    check_val("rot_frozen", ang_o[0], 3);

    keycode = '0; Reset = 1'b1; tick(); Reset = 1'b0; tick();
    keycode = {56'h0, K_W};
    prev_x = x_o[1];
    repeat (400) begin
      tick();
      if (x_o[1] < prev_x) check_val("wrap_edge", edge_o[1], 1);
      prev_x = x_o[1];
    end
    check_val("clamp_x", x_o[0], 623);
    keycode = {56'h0, K_A};
    repeat (300) tick();
    check_val("clamp_ylo", y_o[0], 16);
    keycode = {56'h0, K_D};
    repeat (500) tick();
    check_val("clamp_yhi", y_o[0], 463);

    keycode = {56'h0, K_W}; respawn = 1'b1;
    tick();
    respawn = 1'b0;
    check_val("resp_state", st_o[0], 2); check_val("resp_x", x_o[0], 320);
    check_val("resp_y", y_o[0], 240);    check_val("resp_ang", ang_o[0], 0);
    repeat (59) begin random_keys(); tick(); end
    check_val("resp_last", st_o[0], 2);
    tick();
    check_val("resp_done", st_o[0], 1);
    respawn = 1'b1; tick(); respawn = 1'b0;
    repeat (29) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    check_val("resp_reset", st_o[0], 0);

    for (int seg = 0; seg < 150; seg++) begin
      random_keys();
      enable  = ($urandom_range(0, 9) != 0);
      Reset   = ($urandom_range(0, 59) == 0);
      respawn = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 30);
      tick();
      Reset = 1'b0; respawn = 1'b0;
      repeat (hold) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
